actbuf_port_arbiter: RTL and testbench

Shares the single-port activation buffer SRAM between four requesters. These are external bus write (ifmap stream-in), external bus read (ofmap stream-out), internal read (feature-loader fetch) and internal write (ofmap writeback). Each cycle it grants at most one valid/ready request, issues it to the SRAM, and routes read data back to the issuing requester after a fixed SRAM latency. It sits between the QRAcc controller's activation-buffer control fields and the activation buffer macro.

---
 rtl/actbuf_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_actbuf_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actbuf_port_arbiter.sv
// Four-way arbiter sharing the single-port activation buffer SRAM between
// internal/external readers and writers, with starvation forcing and read-return routing.
module actbuf_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iwr_valid,
    output logic              iwr_ready,
    input  logic [ADDR_W-1:0] iwr_addr,
    input  logic [DATA_W-1:0] iwr_data,
    input  logic              ird_valid,
    output logic              ird_ready,
    input  logic [ADDR_W-1:0] ird_addr,
    output logic              ird_rdata_valid,
    input  logic              ewr_valid,
    output logic              ewr_ready,
    input  logic [ADDR_W-1:0] ewr_addr,
    input  logic [DATA_W-1:0] ewr_data,
    input  logic              erd_valid,
    output logic              erd_ready,
    input  logic [ADDR_W-1:0] erd_addr,
    output logic              erd_rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant_id,
    output logic              starve_event
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [1:0] ID_IWR = 2'd0;
    localparam logic [1:0] ID_IRD = 2'd1;
    localparam logic [1:0] ID_EWR = 2'd2;
    localparam logic [1:0] ID_ERD = 2'd3;

    logic [7:0]            ewr_wait_reg;
    logic [7:0]            erd_wait_reg;
    logic [1:0]            grant_id_reg;
    logic [RD_LATENCY-1:0] pipe_valid_reg;
    logic [RD_LATENCY-1:0] pipe_ext_reg;

    logic       ewr_force;
    logic       erd_force;
    logic       has_win;
    logic [1:0] win_id;
    logic [3:0] gnt;
    logic       ret_valid;

    // A starved external request overrides base priority; erd beats ewr on a tie.
    assign erd_force = !rst && erd_valid && (erd_wait_reg >= LIMIT);
    assign ewr_force = !rst && ewr_valid && (ewr_wait_reg >= LIMIT);

    always_comb begin
        has_win = 1'b0;
        win_id  = ID_IWR;
        if (!rst) begin
            has_win = 1'b1;
            if (erd_force)      win_id = ID_ERD;
            else if (ewr_force) win_id = ID_EWR;
            else if (iwr_valid) win_id = ID_IWR;
            else if (ird_valid) win_id = ID_IRD;
            else if (erd_valid) win_id = ID_ERD;
            else if (ewr_valid) win_id = ID_EWR;
            else                has_win = 1'b0;
        end
    end

    assign gnt          = has_win ? (4'b0001 << win_id) : 4'b0000;
    assign iwr_ready    = gnt[ID_IWR];
    assign ird_ready    = gnt[ID_IRD];
    assign ewr_ready    = gnt[ID_EWR];
    assign erd_ready    = gnt[ID_ERD];
    assign starve_event = erd_force || ewr_force;

    always_comb begin
        mem_en    = has_win;
        mem_wen   = has_win && (win_id == ID_IWR || win_id == ID_EWR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (has_win) begin
            case (win_id)
                ID_IWR: begin
                    mem_addr  = iwr_addr;
                    mem_wdata = iwr_data;
                end
                ID_IRD: mem_addr = ird_addr;
                ID_EWR: begin
                    mem_addr  = ewr_addr;
                    mem_wdata = ewr_data;
                end
                default: mem_addr = erd_addr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ewr_wait_reg <= '0;
            erd_wait_reg <= '0;
            grant_id_reg <= '0;
        end else begin
            if (ewr_valid && !gnt[ID_EWR])
                ewr_wait_reg <= (ewr_wait_reg == 8'hFF) ? 8'hFF : ewr_wait_reg + 8'd1;
            else
                ewr_wait_reg <= '0;
            if (erd_valid && !gnt[ID_ERD])
                erd_wait_reg <= (erd_wait_reg == 8'hFF) ? 8'hFF : erd_wait_reg + 8'd1;
            else
                erd_wait_reg <= '0;
            if (has_win)
                grant_id_reg <= win_id;
        end
    end

    assign grant_id = grant_id_reg;

    // Return pipeline mirrors the SRAM read latency; each stage tags the issuing reader.
    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_ret
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_valid_reg[0] <= 1'b0;
                        pipe_ext_reg[0]   <= 1'b0;
                    end else begin
                        pipe_valid_reg[0] <= gnt[ID_IRD] || gnt[ID_ERD];
                        pipe_ext_reg[0]   <= gnt[ID_ERD];
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_ext_reg[gi]   <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                        pipe_ext_reg[gi]   <= pipe_ext_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign ret_valid       = !rst && pipe_valid_reg[RD_LATENCY-1];
    assign ird_rdata_valid = ret_valid && !pipe_ext_reg[RD_LATENCY-1];
    assign erd_rdata_valid = ret_valid && pipe_ext_reg[RD_LATENCY-1];
    assign rdata           = ret_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_actbuf_port_arbiter.sv
// Randomized and directed bench for actbuf_port_arbiter, checked every cycle
// against a request-level reference model with an SRAM stand-in.
module tb_actbuf_port_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          iwr_valid = 1'b0, ird_valid = 1'b0, ewr_valid = 1'b0, erd_valid = 1'b0;
    logic [AW-1:0] iwr_addr = '0, ird_addr = '0, ewr_addr = '0, erd_addr = '0;
    logic [DW-1:0] iwr_data = '0, ewr_data = '0;
    logic          iwr_ready, ird_ready, ewr_ready, erd_ready;
    logic          ird_rdata_valid, erd_rdata_valid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    grant_id;
    logic          starve_event;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    actbuf_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .iwr_valid(iwr_valid), .iwr_ready(iwr_ready), .iwr_addr(iwr_addr), .iwr_data(iwr_data),
        .ird_valid(ird_valid), .ird_ready(ird_ready), .ird_addr(ird_addr),
        .ird_rdata_valid(ird_rdata_valid),
        .ewr_valid(ewr_valid), .ewr_ready(ewr_ready), .ewr_addr(ewr_addr), .ewr_data(ewr_data),
        .erd_valid(erd_valid), .erd_ready(erd_ready), .erd_addr(erd_addr),
        .erd_rdata_valid(erd_rdata_valid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .grant_id(grant_id), .starve_event(starve_event)
    );

    // SRAM stand-in: writes land at the edge, reads return LAT cycles after issue.
    logic [DW-1:0] sram    [256];
    logic [DW-1:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= '0;
        end else if (mem_en && mem_wen) begin
            sram[mem_addr[7:0]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_wen) ? sram[mem_addr[7:0]] : '0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: request-level view of the arbiter plus an ordered return queue.
    typedef struct {
        int            due;
        bit            ext;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          retq[$];
    logic [DW-1:0] model_mem [256];
    int            cyc     = 0;
    int            ewr_w   = 0;
    int            erd_w   = 0;
    logic [1:0]    exp_gid = 2'd0;

    always @(negedge clk) begin
        int            w;
        logic          fe, fw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_iv, e_ev;
        logic [DW-1:0] e_rdata;
        check("m_gid", 64'(grant_id), 64'(exp_gid));
        if (rst) begin
            check("m_ready_rst", 64'({iwr_ready, ird_ready, ewr_ready, erd_ready}), 64'(0));
            check("m_mem_rst", 64'({mem_en, mem_wen}), 64'(0));
            check("m_ret_rst", 64'({ird_rdata_valid, erd_rdata_valid}), 64'(0));
            check("m_starve_rst", 64'(starve_event), 64'(0));
            ewr_w   = 0;
            erd_w   = 0;
            exp_gid = 2'd0;
            retq.delete();
            for (int i = 0; i < 256; i++) model_mem[i] = '0;
        end else begin
            fe = erd_valid && (erd_w >= LIMIT);
            fw = ewr_valid && (ewr_w >= LIMIT);
            if (fe)             w = 3;
            else if (fw)        w = 2;
            else if (iwr_valid) w = 0;
            else if (ird_valid) w = 1;
            else if (erd_valid) w = 3;
            else if (ewr_valid) w = 2;
            else                w = -1;
            e_addr  = '0;
            e_wdata = '0;
            case (w)
                0: begin e_addr = iwr_addr; e_wdata = iwr_data; end
                1: e_addr = ird_addr;
                2: begin e_addr = ewr_addr; e_wdata = ewr_data; end
                3: e_addr = erd_addr;
                default: ;
            endcase
            e_iv    = 1'b0;
            e_ev    = 1'b0;
            e_rdata = '0;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                e_iv    = !retq[0].ext;
                e_ev    = retq[0].ext;
                e_rdata = retq[0].data;
                void'(retq.pop_front());
            end
            check("m_ready", 64'({iwr_ready, ird_ready, ewr_ready, erd_ready}),
                  64'({w == 0, w == 1, w == 2, w == 3}));
            check("m_mem", 64'({mem_en, mem_wen, mem_addr, mem_wdata}),
                  64'({w >= 0, (w == 0 || w == 2), e_addr, e_wdata}));
            check("m_starve", 64'(starve_event), 64'(fe || fw));
            check("m_ret", 64'({ird_rdata_valid, erd_rdata_valid}), 64'({e_iv, e_ev}));
            if (e_iv || e_ev) check("m_rdata", 64'(rdata), 64'(e_rdata));
            if (w >= 0) begin
                $display("[TB] cyc %0d grant %0d addr %0h%s", cyc, w, e_addr,
                         (fe || fw) ? " starve" : "");
                if (w == 0 || w == 2) model_mem[e_addr[7:0]] = e_wdata;
                else retq.push_back('{due: cyc + LAT, ext: (w == 3), data: model_mem[e_addr[7:0]]});
                exp_gid = 2'(w);
            end
            erd_w = (erd_valid && w != 3) ? ((erd_w < 255) ? erd_w + 1 : 255) : 0;
            ewr_w = (ewr_valid && w != 2) ? ((ewr_w < 255) ? ewr_w + 1 : 255) : 0;
        end
        cyc++;
    end

    int         prio_exp [4] = '{0, 1, 3, 2};
    int         got;
    logic [3:0] fired;
    int         p_i, p_e;

    initial begin
        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_ready", 64'({iwr_ready, ird_ready, ewr_ready, erd_ready}), 64'(0));
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        tick();
        rst = 1'b0;

        // Single requester write then read
        ewr_valid = 1'b1; ewr_addr = 16'h0010; ewr_data = 32'hDEADBEEF;
        @(negedge clk);
        check("single_ewr_ready", 64'(ewr_ready), 64'(1));
        check("single_wen", 64'(mem_wen), 64'(1));
        tick();
        ewr_valid = 1'b0; erd_valid = 1'b1; erd_addr = 16'h0010;
        @(negedge clk);
        check("single_erd_ready", 64'(erd_ready), 64'(1));
        tick();
        erd_valid = 1'b0;
        repeat (LAT - 1) tick();
        @(negedge clk);
        check("single_erd_rv", 64'(erd_rdata_valid), 64'(1));
        check("single_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        tick();

        // Priority with all four pending
        iwr_valid = 1'b1; iwr_addr = 16'h0020; iwr_data = 32'h11111111;
        ird_valid = 1'b1; ird_addr = 16'h0010;
        erd_valid = 1'b1; erd_addr = 16'h0010;
        ewr_valid = 1'b1; ewr_addr = 16'h0021; ewr_data = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = -1;
            if (iwr_ready) got = 0;
            if (ird_ready) got = 1;
            if (ewr_ready) got = 2;
            if (erd_ready) got = 3;
            check("prio_onehot", 64'($countones({iwr_ready, ird_ready, ewr_ready, erd_ready})), 64'(1));
            check("prio_order", 64'(got), 64'(prio_exp[k]));
            tick();
            case (got)
                0: iwr_valid = 1'b0;
                1: ird_valid = 1'b0;
                2: ewr_valid = 1'b0;
                3: erd_valid = 1'b0;
                default: ;
            endcase
        end
        iwr_valid = 1'b0; ird_valid = 1'b0; ewr_valid = 1'b0; erd_valid = 1'b0;
        repeat (LAT + 1) tick();

        // Starvation of ewr behind continuous internal traffic
        iwr_valid = 1'b1; iwr_addr = 16'h0040; iwr_data = 32'h00000033;
        ird_valid = 1'b1; ird_addr = 16'h0041;
        ewr_valid = 1'b1; ewr_addr = 16'h0042; ewr_data = 32'h00000044;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                check("starve_iwr_wins", 64'(iwr_ready), 64'(1));
                check("starve_quiet", 64'(starve_event), 64'(0));
            end else begin
                check("starve_ewr_forced", 64'(ewr_ready), 64'(1));
                check("starve_event", 64'(starve_event), 64'(1));
                check("starve_iwr_stall", 64'(iwr_ready), 64'(0));
            end
            tick();
        end
        // Both external requests reach the limit together
        ewr_valid = 1'b1; erd_valid = 1'b1; erd_addr = 16'h0040;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c < 4) check("tie_iwr_wins", 64'(iwr_ready), 64'(1));
            else if (c == 4) check("tie_erd_first", 64'({erd_ready, starve_event}), 64'(2'b11));
            else check("tie_ewr_next", 64'({ewr_ready, starve_event}), 64'(2'b11));
            tick();
            if (c == 4) erd_valid = 1'b0;
        end
        iwr_valid = 1'b0; ewr_valid = 1'b0;
        @(negedge clk);
        check("starve_ird_after", 64'(ird_ready), 64'(1));
        tick();
        ird_valid = 1'b0;
        repeat (LAT + 1) tick();

        // Alternating read return routing
        iwr_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            iwr_addr = 16'(16'h0030 + j);
            iwr_data = 32'hA0000000 + 32'(j);
            @(negedge clk);
            check("route_fill", 64'(iwr_ready), 64'(1));
            tick();
        end
        iwr_valid = 1'b0;
        ird_valid = 1'b1; ird_addr = 16'h0030;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j < 6) check("route_grant", 64'((j % 2 == 0) ? ird_ready : erd_ready), 64'(1));
            if (j >= 3) begin
                check("route_ird_rv", 64'(ird_rdata_valid), 64'((j - 3) % 2 == 0));
                check("route_erd_rv", 64'(erd_rdata_valid), 64'((j - 3) % 2 == 1));
                check("route_data", 64'(rdata), 64'(32'hA0000000 + 32'(j - 3)));
            end
            tick();
            ird_valid = (j + 1 < 6) && ((j + 1) % 2 == 0);
            erd_valid = (j + 1 < 6) && ((j + 1) % 2 == 1);
            ird_addr  = 16'(16'h0030 + j + 1);
            erd_addr  = 16'(16'h0030 + j + 1);
        end
        ird_valid = 1'b0; erd_valid = 1'b0;
        tick();

        // Reset while a read is in flight
        ird_valid = 1'b1; ird_addr = 16'h0031;
        @(negedge clk);
        check("flight_grant", 64'(ird_ready), 64'(1));
        tick();
        ird_valid = 1'b0;
        rst = 1'b1;
        iwr_valid = 1'b1; iwr_addr = 16'h0050; iwr_data = 32'h00000055;
        @(negedge clk);
        check("flight_rst_ready", 64'({iwr_ready, ird_ready, ewr_ready, erd_ready}), 64'(0));
        check("flight_rst_out", 64'({mem_en, mem_wen, starve_event, ird_rdata_valid, erd_rdata_valid}), 64'(0));
        check("flight_rst_bus", 64'({mem_addr, mem_wdata}), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("flight_resume", 64'(iwr_ready), 64'(1));
        check("flight_gid", 64'(grant_id), 64'(0));
        tick();
        iwr_valid = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            check("flight_no_rv", 64'(ird_rdata_valid), 64'(0));
            tick();
        end

        // Write then read of the same address
        iwr_valid = 1'b1; iwr_addr = 16'h0005; iwr_data = 32'h00001234;
        ird_valid = 1'b1; ird_addr = 16'h0005;
        @(negedge clk);
        check("hazard_write_first", 64'({iwr_ready, ird_ready}), 64'(2'b10));
        tick();
        iwr_valid = 1'b0;
        @(negedge clk);
        check("hazard_read_next", 64'(ird_ready), 64'(1));
        tick();
        ird_valid = 1'b0;
        repeat (LAT - 1) tick();
        @(negedge clk);
        check("hazard_rv", 64'(ird_rdata_valid), 64'(1));
        check("hazard_rdata", 64'(rdata), 64'(32'h00001234));
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            fired = {erd_valid && erd_ready, ewr_valid && ewr_ready,
                     ird_valid && ird_ready, iwr_valid && iwr_ready};
            tick();
            case (c / 500)
                0:       begin p_i = 30; p_e = 30; end
                1:       begin p_i = 90; p_e = 60; end
                default: begin p_i = 70; p_e = 70; end
            endcase
            rst = ($urandom_range(0, 199) == 0);
            if (!iwr_valid || fired[0]) begin
                iwr_valid = ($urandom_range(0, 99) < p_i);
                iwr_addr  = 16'($urandom_range(0, 15));
                iwr_data  = $urandom;
            end
            if (!ird_valid || fired[1]) begin
                ird_valid = ($urandom_range(0, 99) < p_i);
                ird_addr  = 16'($urandom_range(0, 15));
            end
            if (!ewr_valid || fired[2]) begin
                ewr_valid = ($urandom_range(0, 99) < p_e);
                ewr_addr  = 16'($urandom_range(0, 15));
                ewr_data  = $urandom;
            end
            if (!erd_valid || fired[3]) begin
                erd_valid = ($urandom_range(0, 99) < p_e);
                erd_addr  = 16'($urandom_range(0, 15));
            end
        end
        rst = 1'b0;
        iwr_valid = 1'b0; ird_valid = 1'b0; ewr_valid = 1'b0; erd_valid = 1'b0;
        repeat (LAT + 3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
